// File: rtl/rob_pkg.sv
// Shared constants and state encoding for the reorder buffer.
package rob_pkg;

  localparam int ROB_BIT  = 3;
  localparam int ROB_SIZE = 1 << ROB_BIT;

  localparam logic [ROB_BIT:0]   FULL_COUNT = {1'b1, {ROB_BIT{1'b0}}};
  localparam logic [ROB_BIT:0]   CNT_ONE    = {{ROB_BIT{1'b0}}, 1'b1};
  localparam logic [ROB_BIT-1:0] PTR_ONE    = {{(ROB_BIT-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rob_state_e;

endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup: CDB bypass first, then the stored entry result.
module rob_query
  import rob_pkg::*;
(
  input  logic                     [ROB_BIT-1:0] entry_i,
  input  logic                    [ROB_SIZE-1:0] busy_i,
  input  logic                    [ROB_SIZE-1:0] ready_i,
  input  logic [ROB_SIZE-1:0][31:0]              value_i,
  input  logic                                   wb_valid_i,
  input  logic                     [ROB_BIT-1:0] wb_entry_i,
  input  logic                            [31:0] wb_value_i,
  output logic                                   ready_o,
  output logic                            [31:0] value_o
);

  always_comb begin
    ready_o = 1'b0;
    value_o = '0;
    if (wb_valid_i && (wb_entry_i == entry_i)) begin
      ready_o = 1'b1;
      value_o = wb_value_i;
    end else if (busy_i[entry_i] && ready_i[entry_i]) begin
      ready_o = 1'b1;
      value_o = value_i[entry_i];
    end
  end

endmodule

// File: rtl/rob_core.sv
// Reorder buffer: in-order allocation, out-of-order completion, in-order commit,
// and a one-cycle flush after a mispredicted branch commits.
module rob_core
  import rob_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  output logic [ROB_BIT-1:0] issue_rob_entry,
  output logic [4:0]         issue_reg_id,
  output logic               rob_full,
  input  logic               wb_valid,
  input  logic [ROB_BIT-1:0] wb_rob_entry,
  input  logic [31:0]        wb_value,
  input  logic               wb_mispredict,
  input  logic [31:0]        wb_target_pc,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               rob_clear_up,
  output logic [31:0]        clear_pc,
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  output logic               ready1,
  output logic [31:0]        value1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready2,
  output logic [31:0]        value2,
  output logic               dbg_state_o
);

  rob_state_e state_q;
  logic [ROB_BIT-1:0] head_q, tail_q;
  logic [ROB_BIT:0]   count_q, count_d;

  logic [ROB_SIZE-1:0]       busy_q, ready_q, mis_q;
  logic [ROB_SIZE-1:0][4:0]  rd_q;
  logic [ROB_SIZE-1:0][31:0] value_q, target_q;

  logic [4:0]         commit_id_q;
  logic [31:0]        commit_data_q;
  logic [ROB_BIT-1:0] commit_entry_q;
  logic               clear_q;
  logic [31:0]        clear_pc_q;

  logic issue_fire, commit_fire;

  // Fullness uses the registered count only, so a commit this cycle frees nothing until next.
  assign rob_full        = (count_q == FULL_COUNT) || (state_q == ST_FLUSH);
  assign issue_fire      = issue_valid && !rob_full && rdy_in;
  assign issue_rob_entry = tail_q;
  assign issue_reg_id    = issue_fire ? issue_rd : 5'd0;

  assign commit_fire = (state_q == ST_RUN) && (count_q != '0) && busy_q[head_q] && ready_q[head_q];

  always_comb begin
    count_d = count_q;
    if (issue_fire && !commit_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (!issue_fire && commit_fire) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= ST_RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      mis_q          <= '0;
      rd_q           <= '0;
      value_q        <= '0;
      target_q       <= '0;
      commit_id_q    <= '0;
      commit_data_q  <= '0;
      commit_entry_q <= '0;
      clear_q        <= 1'b0;
      clear_pc_q     <= '0;
    end else if (rdy_in) begin
      commit_id_q <= '0;
      clear_q     <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (wb_valid && busy_q[wb_rob_entry]) begin
            ready_q[wb_rob_entry]  <= 1'b1;
            value_q[wb_rob_entry]  <= wb_value;
            mis_q[wb_rob_entry]    <= wb_mispredict;
            target_q[wb_rob_entry] <= wb_target_pc;
          end
          if (commit_fire) begin
            commit_id_q    <= rd_q[head_q];
            commit_data_q  <= value_q[head_q];
            commit_entry_q <= head_q;
            busy_q[head_q] <= 1'b0;
            head_q         <= head_q + PTR_ONE;
            // The branch's own rd write goes out now; the clear follows a cycle later.
            if (mis_q[head_q]) begin
              clear_pc_q <= target_q[head_q];
              state_q    <= ST_FLUSH;
            end
          end
          if (issue_fire) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            mis_q[tail_q]   <= 1'b0;
            rd_q[tail_q]    <= issue_rd;
            tail_q          <= tail_q + PTR_ONE;
          end
          count_q <= count_d;
        end
        ST_FLUSH: begin
          clear_q <= 1'b1;
          busy_q  <= '0;
          ready_q <= '0;
          head_q  <= '0;
          tail_q  <= '0;
          count_q <= '0;
          state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign commit_reg_id    = commit_id_q;
  assign commit_reg_data  = commit_data_q;
  assign commit_rob_entry = commit_entry_q;
  assign rob_clear_up     = clear_q;
  assign clear_pc         = clear_pc_q;
  assign dbg_state_o      = state_q;

  rob_query u_query1 (
    .entry_i    (get_rob_entry1),
    .busy_i     (busy_q),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .wb_valid_i (wb_valid),
    .wb_entry_i (wb_rob_entry),
    .wb_value_i (wb_value),
    .ready_o    (ready1),
    .value_o    (value1)
  );

  rob_query u_query2 (
    .entry_i    (get_rob_entry2),
    .busy_i     (busy_q),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .wb_valid_i (wb_valid),
    .wb_entry_i (wb_rob_entry),
    .wb_value_i (wb_value),
    .ready_o    (ready2),
    .value_o    (value2)
  );

endmodule

// File: tb/tb_rob_core.sv
// Bench for rob_core: directed scenarios plus a randomized run against a program-order queue model.
module tb_rob_core;
  import rob_pkg::*;

  logic        clk_in, rst_in, rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [2:0]  issue_rob_entry;
  logic [4:0]  issue_reg_id;
  logic        rob_full;
  logic        wb_valid;
  logic [2:0]  wb_rob_entry;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic [31:0] wb_target_pc;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_data;
  logic [2:0]  commit_rob_entry;
  logic        rob_clear_up;
  logic [31:0] clear_pc;
  logic [2:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  rob_core dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_entry(issue_rob_entry),
    .issue_reg_id(issue_reg_id), .rob_full(rob_full),
    .wb_valid(wb_valid), .wb_rob_entry(wb_rob_entry), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target_pc(wb_target_pc),
    .commit_reg_id(commit_reg_id), .commit_reg_data(commit_reg_data),
    .commit_rob_entry(commit_rob_entry), .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
    .get_rob_entry1(get_rob_entry1), .ready1(ready1), .value1(value1),
    .get_rob_entry2(get_rob_entry2), .ready2(ready2), .value2(value2),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  idx;
    logic [4:0]  rd;
    logic        done;
    logic [31:0] value;
    logic        mis;
    logic [31:0] tgt;
  } m_ent_t;

  m_ent_t      m_q[$];      // in-flight instructions, oldest first
  logic [2:0]  m_tail;
  logic        m_flush;     // a mispredicted branch has committed; clear pending
  logic        m_commit;    // last active edge committed something
  logic        m_clear;     // last active edge produced the clear pulse
  logic [31:0] m_pc;
  logic [39:0] exp_q[$];    // expected commits {rd, value, entry}

  function automatic void m_query(input logic [2:0] g, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'h0;
    if (wb_valid && wb_rob_entry == g) begin
      r = 1'b1;
      v = wb_value;
    end else begin
      foreach (m_q[i]) if (m_q[i].idx == g && m_q[i].done) begin
        r = 1'b1;
        v = m_q[i].value;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int iv, input int rd, input int wv, input int we,
                       input logic [31:0] wval, input int wm, input logic [31:0] wt);
    issue_valid   = (iv != 0);
    issue_rd      = 5'(rd);
    wb_valid      = (wv != 0);
    wb_rob_entry  = 3'(we);
    wb_value      = wval;
    wb_mispredict = (wm != 0);
    wb_target_pc  = wt;
    #1;
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic tick();
    logic   commit, accept;
    m_ent_t front;
    if (rdy_in) begin
      m_clear  = 1'b0;
      m_commit = 1'b0;
      if (m_flush) begin
        m_q.delete();
        m_tail  = 3'd0;
        m_flush = 1'b0;
        m_clear = 1'b1;
      end else begin
        commit = (m_q.size() > 0) && m_q[0].done;
        accept = issue_valid && (m_q.size() < 8);
        if (commit) front = m_q[0];
        if (wb_valid) foreach (m_q[i]) if (m_q[i].idx == wb_rob_entry) begin
          m_q[i].done  = 1'b1;
          m_q[i].value = wb_value;
          m_q[i].mis   = wb_mispredict;
          m_q[i].tgt   = wb_target_pc;
        end
        if (commit) begin
          void'(m_q.pop_front());
          m_commit = 1'b1;
          exp_q.push_back({front.rd, front.value, front.idx});
          if (front.mis) begin
            m_flush = 1'b1;
            m_pc    = front.tgt;
          end
        end
        if (accept) begin
          m_q.push_back('{m_tail, issue_rd, 1'b0, 32'h0, 1'b0, 32'h0});
          m_tail = m_tail + 3'd1;
        end
      end
    end
    @(posedge clk_in);
    #1;
    @(negedge clk_in);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    rdy_in = 1'b1;
    get_rob_entry1 = 3'd0;
    get_rob_entry2 = 3'd0;
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_tail = 3'd0; m_flush = 1'b0; m_commit = 1'b0; m_clear = 1'b0; m_pc = 32'h0;
    @(negedge clk_in);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    drive(1, 3, 0, 0, 32'h0, 0, 32'h0); tick();
    drive(1, 4, 1, 0, 32'h33, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    checks++; if (commit_reg_id !== 5'd3) begin errors++; $display("FAIL rst_pre_commit: got %0d exp 3", commit_reg_id); end
    rst_in = 1'b1;
    #1;
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b exp 0", rob_full); end
    checks++; if (issue_rob_entry !== 3'd0) begin errors++; $display("FAIL rst_tail: got %0d exp 0", issue_rob_entry); end
    checks++; if (commit_reg_id !== 5'd0) begin errors++; $display("FAIL rst_commit: got %0d exp 0", commit_reg_id); end
    checks++; if (rob_clear_up !== 1'b0) begin errors++; $display("FAIL rst_clear: got %b exp 0", rob_clear_up); end
    rst_in = 1'b0;
    m_q.delete(); exp_q.delete();
    m_tail = 3'd0; m_flush = 1'b0; m_commit = 1'b0; m_clear = 1'b0;
    @(negedge clk_in);
    checks++; if (issue_rob_entry !== 3'd0) begin errors++; $display("FAIL rst_tail_after: got %0d exp 0", issue_rob_entry); end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, i + 1, 0, 0, 32'h0, 0, 32'h0);
      checks++; if (issue_rob_entry !== 3'(i)) begin errors++; $display("FAIL ooo_entry: got %0d exp %0d", issue_rob_entry, i); end
      checks++; if (issue_reg_id !== 5'(i + 1)) begin errors++; $display("FAIL ooo_regid: got %0d exp %0d", issue_reg_id, i + 1); end
      tick();
    end
    drive(0, 0, 1, 1, 32'h22, 0, 32'h0); tick();
    checks++; if (commit_reg_id !== 5'd0) begin errors++; $display("FAIL ooo_early: got %0d exp 0", commit_reg_id); end
    drive(0, 0, 1, 0, 32'h11, 0, 32'h0); tick();
    checks++; if (commit_reg_id !== 5'd0) begin errors++; $display("FAIL ooo_wait: got %0d exp 0", commit_reg_id); end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    checks++; if ({commit_reg_id, commit_reg_data, commit_rob_entry} !== {5'd1, 32'h11, 3'd0}) begin
      errors++; $display("FAIL ooo_c0: got %0d/%h/%0d exp 1/11/0", commit_reg_id, commit_reg_data, commit_rob_entry); end
    tick();
    checks++; if ({commit_reg_id, commit_reg_data, commit_rob_entry} !== {5'd2, 32'h22, 3'd1}) begin
      errors++; $display("FAIL ooo_c1: got %0d/%h/%0d exp 2/22/1", commit_reg_id, commit_reg_data, commit_rob_entry); end
    tick();
    checks++; if (commit_reg_id !== 5'd0) begin errors++; $display("FAIL ooo_c2_pending: got %0d exp 0", commit_reg_id); end
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, i + 1, 0, 0, 32'h0, 0, 32'h0);
      checks++; if (rob_full !== 1'b0 || issue_rob_entry !== 3'(i)) begin
        errors++; $display("FAIL full_fill: full %b entry %0d exp 0/%0d", rob_full, issue_rob_entry, i); end
      tick();
    end
    drive(1, 9, 1, 0, 32'hA, 0, 32'h0);
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b exp 1", rob_full); end
    checks++; if (issue_reg_id !== 5'd0) begin errors++; $display("FAIL full_regid: got %0d exp 0", issue_reg_id); end
    tick();
    drive(1, 9, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (rob_full !== 1'b1) begin errors++; $display("FAIL full_no_credit: got %b exp 1", rob_full); end
    tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (rob_full !== 1'b0) begin errors++; $display("FAIL full_freed: got %b exp 0", rob_full); end
    checks++; if (issue_rob_entry !== 3'd0) begin errors++; $display("FAIL full_wrap: got %0d exp 0", issue_rob_entry); end
    checks++; if ({commit_reg_id, commit_reg_data, commit_rob_entry} !== {5'd1, 32'hA, 3'd0}) begin
      errors++; $display("FAIL full_commit: got %0d/%h/%0d exp 1/a/0", commit_reg_id, commit_reg_data, commit_rob_entry); end
  endtask

  task automatic test_bypass();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, i + 1, 0, 0, 32'h0, 0, 32'h0); tick();
    end
    get_rob_entry1 = 3'd4;
    get_rob_entry2 = 3'd5;
    drive(0, 0, 1, 4, 32'hDEAD, 0, 32'h0);
    checks++; if (ready1 !== 1'b1 || value1 !== 32'hDEAD) begin
      errors++; $display("FAIL byp_1: got %b/%h exp 1/dead", ready1, value1); end
    checks++; if (ready2 !== 1'b0 || value2 !== 32'h0) begin
      errors++; $display("FAIL byp_2: got %b/%h exp 0/0", ready2, value2); end
    tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (ready1 !== 1'b1 || value1 !== 32'hDEAD) begin
      errors++; $display("FAIL byp_stored: got %b/%h exp 1/dead", ready1, value1); end
  endtask

  task automatic test_mispredict();
    int rds[6] = '{1, 2, 0, 4, 5, 6};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, rds[i], 0, 0, 32'h0, 0, 32'h0); tick();
    end
    drive(0, 0, 1, 0, 32'h1, 0, 32'h0); tick();
    drive(0, 0, 1, 1, 32'h2, 0, 32'h0); tick();
    drive(0, 0, 1, 2, 32'h0, 1, 32'h100); tick();
    drive(0, 0, 1, 3, 32'h33, 0, 32'h0); tick();
    checks++; if (commit_rob_entry !== 3'd2 || commit_reg_id !== 5'd0 || rob_clear_up !== 1'b0) begin
      errors++; $display("FAIL mis_branch_commit: entry %0d id %0d clear %b exp 2/0/0", commit_rob_entry, commit_reg_id, rob_clear_up); end
    checks++; if (dbg_state !== 1'(ST_FLUSH)) begin errors++; $display("FAIL mis_state: got %b exp flush", dbg_state); end
    get_rob_entry1 = 3'd3;
    drive(1, 7, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (rob_full !== 1'b1 || issue_reg_id !== 5'd0) begin
      errors++; $display("FAIL mis_refuse: full %b id %0d exp 1/0", rob_full, issue_reg_id); end
    checks++; if (ready1 !== 1'b1 || value1 !== 32'h33) begin
      errors++; $display("FAIL mis_query_pre: got %b/%h exp 1/33", ready1, value1); end
    tick();
    checks++; if (rob_clear_up !== 1'b1 || clear_pc !== 32'h100 || commit_reg_id !== 5'd0) begin
      errors++; $display("FAIL mis_clear: clear %b pc %h id %0d exp 1/100/0", rob_clear_up, clear_pc, commit_reg_id); end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (issue_rob_entry !== 3'd0 || ready1 !== 1'b0) begin
      errors++; $display("FAIL mis_reset_ptr: entry %0d ready %b exp 0/0", issue_rob_entry, ready1); end
    tick();
    checks++; if (rob_clear_up !== 1'b0) begin errors++; $display("FAIL mis_pulse_len: got %b exp 0", rob_clear_up); end
    drive(1, 7, 0, 0, 32'h0, 0, 32'h0);
    checks++; if (issue_rob_entry !== 3'd0 || issue_reg_id !== 5'd7) begin
      errors++; $display("FAIL mis_reissue: entry %0d id %0d exp 0/7", issue_rob_entry, issue_reg_id); end
    tick();
  endtask

  task automatic test_pause();
    int writes = 0;
    apply_reset();
    drive(1, 5, 0, 0, 32'h0, 0, 32'h0); tick();
    drive(0, 0, 1, 0, 32'h7, 0, 32'h0); tick();
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0); tick();
    for (int i = 0; i < 3; i++) begin
      rdy_in = 1'b0;
      drive(1, 9, 0, 0, 32'h0, 0, 32'h0);
      checks++; if ({commit_reg_id, commit_reg_data, commit_rob_entry} !== {5'd5, 32'h7, 3'd0}) begin
        errors++; $display("FAIL pause_hold: got %0d/%h/%0d exp 5/7/0", commit_reg_id, commit_reg_data, commit_rob_entry); end
      if (rdy_in && commit_reg_id != 5'd0) writes++;
      tick();
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      if (rdy_in && commit_reg_id != 5'd0) writes++;
      tick();
    end
    checks++; if (writes != 1) begin errors++; $display("FAIL pause_writes: got %0d exp 1", writes); end
  endtask

  task automatic test_random();
    logic [2:0]  cand[$];
    logic [4:0]  e_id;
    logic [31:0] e_data, e_pc;
    logic [2:0]  e_ent;
    logic        e_clr, exp_full, r, was_rdy;
    logic [31:0] v;
    int iv, rd, wv, we;
    apply_reset();
    e_id = 5'd0; e_data = 32'h0; e_ent = 3'd0; e_clr = 1'b0; e_pc = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rdy_in = ($urandom_range(0, 9) != 0);
      iv = ($urandom_range(0, 9) < 6) ? 1 : 0;
      rd = int'($urandom_range(1, 31));
      wv = 0; we = 0;
      cand.delete();
      foreach (m_q[i]) if (!m_q[i].done) cand.push_back(m_q[i].idx);
      if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
        wv = 1; we = int'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        wv = 1; we = int'($urandom_range(0, 7));
      end
      get_rob_entry1 = 3'($urandom_range(0, 7));
      get_rob_entry2 = 3'($urandom_range(0, 7));
      drive(iv, rd, wv, we, $urandom, ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom);
      exp_full = (m_q.size() == 8) || m_flush;
      checks++; if (rob_full !== exp_full) begin errors++; $display("FAIL rnd_full c%0d: got %b exp %b", cyc, rob_full, exp_full); end
      checks++; if (issue_rob_entry !== m_tail) begin errors++; $display("FAIL rnd_tail c%0d: got %0d exp %0d", cyc, issue_rob_entry, m_tail); end
      checks++; if (issue_reg_id !== ((issue_valid && !exp_full && rdy_in) ? issue_rd : 5'd0)) begin
        errors++; $display("FAIL rnd_regid c%0d: got %0d", cyc, issue_reg_id); end
      m_query(get_rob_entry1, r, v);
      checks++; if (ready1 !== r || value1 !== v) begin errors++; $display("FAIL rnd_q1 c%0d: got %b/%h exp %b/%h", cyc, ready1, value1, r, v); end
      m_query(get_rob_entry2, r, v);
      checks++; if (ready2 !== r || value2 !== v) begin errors++; $display("FAIL rnd_q2 c%0d: got %b/%h exp %b/%h", cyc, ready2, value2, r, v); end
      was_rdy = rdy_in;
      tick();
      if (was_rdy) begin
        if (m_commit) {e_id, e_data, e_ent} = exp_q.pop_front();
        else e_id = 5'd0;
        e_clr = m_clear;
        e_pc  = m_pc;
      end
      checks++; if (commit_reg_id !== e_id) begin errors++; $display("FAIL rnd_commit_id c%0d: got %0d exp %0d", cyc, commit_reg_id, e_id); end
      if (e_id != 5'd0) begin
        checks++; if (commit_reg_data !== e_data || commit_rob_entry !== e_ent) begin
          errors++; $display("FAIL rnd_commit c%0d: got %h/%0d exp %h/%0d", cyc, commit_reg_data, commit_rob_entry, e_data, e_ent); end
      end
      checks++; if (rob_clear_up !== e_clr) begin errors++; $display("FAIL rnd_clear c%0d: got %b exp %b", cyc, rob_clear_up, e_clr); end
      if (e_clr) begin
        checks++; if (clear_pc !== e_pc) begin errors++; $display("FAIL rnd_clear_pc c%0d: got %h exp %h", cyc, clear_pc, e_pc); end
      end
    end
    rdy_in = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_out_of_order();
    test_full();
    test_bypass();
    test_mispredict();
    test_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
